// File: rtl/pwm_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_pkg
// Purpose  : Shared types and constants for the PWM soft-start sequencer and
//            the PWM generator wrapper.
// Contents : c_SPEED_W     - default speed-select width (matches generator)
//            ramp_state_t  - sequencer state encoding
// Revision : 1.0 - initial release
// ============================================================================
package pwm_ramp_pkg;

    localparam int c_SPEED_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dwell_timer
// Purpose  : Dwell counter for the ramp sequencer. Counts every cycle, wraps
//            to zero after DWELL-1 and flags that last count with a one-cycle
//            tick.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            clr   - synchronous clear (count returns to 0)
//            tick  - high while the count equals DWELL-1
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dwell_timer #(
    parameter int DWELL   = 1000,
    parameter int DWELL_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [DWELL_W-1:0] c_LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] r_count;

    assign tick = (r_count == c_LAST);

    // Self-wrapping at the tick keeps the period exactly DWELL cycles
    // without the controller having to request a clear on every step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Soft-start / soft-stop sequencer for the PWM generator. Moves
//            the speed select one level per dwell period toward the target
//            and ramps to zero before disabling the generator.
// Option   : PWM_RAMP_ESTOP_EN - adds the estop input and sticky fault output
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            run            - 1 = run at target, 0 = ramp down and stop
//            target         - requested speed level
//            estop, fault   - emergency stop / sticky indication (option)
//            pwm_en         - generator enable
//            pwm_speed      - current speed level
//            busy           - ramping up/down or stopping
//            at_target      - holding at the requested level
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int SPEED_W = c_SPEED_W,
    parameter int DWELL   = 1000,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [SPEED_W-1:0] target,
`ifdef PWM_RAMP_ESTOP_EN
    input  logic               estop,
    output logic               fault,
`endif
    output logic               pwm_en,
    output logic [SPEED_W-1:0] pwm_speed,
    output logic               busy,
    output logic               at_target
);

    ramp_state_t        r_state;
    logic [SPEED_W-1:0] r_cur;
    logic               r_pwm_en;
    logic               r_busy;
    logic               r_at_target;
    logic               w_tick;
    logic               w_clr;
    logic               w_start;

`ifdef PWM_RAMP_ESTOP_EN
    logic               r_fault;

    // A latched fault blocks restart until run has been released.
    assign w_start = run && !r_fault;
    assign fault   = r_fault;
`else
    assign w_start = run;
`endif

    // The counter only runs while a step or stop dwell is being timed; any
    // state change (or staying parked) restarts the dwell from zero.
    always_comb begin
        w_clr = 1'b1;
        case (r_state)
            ST_RAMP: w_clr = !run || (r_cur == target);
            ST_STOP: w_clr = run;
            default: w_clr = 1'b1;
        endcase
`ifdef PWM_RAMP_ESTOP_EN
        if (estop) begin
            w_clr = 1'b1;
        end
`endif
    end

    pwm_dwell_timer #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Outputs are registered from the decision made for the next state, so
    // busy/at_target/pwm_en change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_pwm_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
`ifdef PWM_RAMP_ESTOP_EN
            r_fault     <= 1'b0;
        end else if (estop) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_pwm_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
            r_fault     <= 1'b1;
`endif
        end else begin
`ifdef PWM_RAMP_ESTOP_EN
            if (!run) begin
                r_fault <= 1'b0;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cur <= '0;
                    if (w_start) begin
                        r_state  <= ST_RAMP;
                        r_pwm_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (!run) begin
                        r_state <= ST_STOP;
                    end else if (r_cur == target) begin
                        r_state     <= ST_HOLD;
                        r_busy      <= 1'b0;
                        r_at_target <= 1'b1;
                    end else if (w_tick) begin
                        // Compare against the live target so a mid-ramp
                        // change redirects at the next step.
                        if (r_cur < target) begin
                            r_cur <= r_cur + 1'b1;
                        end else begin
                            r_cur <= r_cur - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!run) begin
                        r_state     <= ST_STOP;
                        r_busy      <= 1'b1;
                        r_at_target <= 1'b0;
                    end else if (target != r_cur) begin
                        r_state     <= ST_RAMP;
                        r_busy      <= 1'b1;
                        r_at_target <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (run) begin
                        r_state <= ST_RAMP;
                    end else if (w_tick) begin
                        if (r_cur != '0) begin
                            r_cur <= r_cur - 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_pwm_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cur       <= '0;
                    r_pwm_en    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_at_target <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_en    = r_pwm_en;
    assign pwm_speed = r_cur;
    assign busy      = r_busy;
    assign at_target = r_at_target;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Purpose  : Self-checking bench for pwm_ramp_ctrl (DWELL = 4). Table-driven
//            ramp/stop vectors, hand-written corner sequences and a random
//            run/target stream compared against a behavioural model.
// Option   : PWM_RAMP_ESTOP_EN - also exercises estop/fault
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    localparam int SPEED_W = 3;
    localparam int DWELL   = 4;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               run = 1'b0;
    logic [SPEED_W-1:0] target = '0;
    logic               pwm_en;
    logic [SPEED_W-1:0] pwm_speed;
    logic               busy;
    logic               at_target;
`ifdef PWM_RAMP_ESTOP_EN
    logic               estop = 1'b0;
    logic               fault;
`endif

    pwm_ramp_ctrl #(
        .SPEED_W (SPEED_W),
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .target    (target),
`ifdef PWM_RAMP_ESTOP_EN
        .estop     (estop),
        .fault     (fault),
`endif
        .pwm_en    (pwm_en),
        .pwm_speed (pwm_speed),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int prev_speed = 0;
    bit jump_ok = 1'b0;
    bit cur_estop = 1'b0;

    typedef struct {
        bit run;
        int tgt;
        int n;
        int en;
        int spd;
        int busy;
        int at;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural model --------------------------------
    // Tracks: generator on/off, level, whether we are winding down, whether
    // we have settled on the target, and cycles elapsed in the current dwell.
    bit m_en, m_stop, m_settled, m_fault;
    int m_cur, m_elapsed;

    function automatic void model_reset();
        m_en = 0; m_stop = 0; m_settled = 0; m_fault = 0;
        m_cur = 0; m_elapsed = 0;
    endfunction

    function automatic void model_edge(bit run_i, int tgt_i, bit estop_i);
        if (estop_i) begin
            m_en = 0; m_cur = 0; m_stop = 0; m_settled = 0;
            m_elapsed = 0; m_fault = 1;
            return;
        end
        if (m_fault && !run_i) m_fault = 0;
        if (!m_en) begin
            m_cur = 0;
            if (run_i && !m_fault) begin
                m_en = 1; m_stop = 0; m_settled = 0; m_elapsed = 0;
            end
        end else if (run_i == m_stop) begin
            // run request flipped: direction of travel changes, dwell restarts
            m_stop = !run_i; m_settled = 0; m_elapsed = 0;
        end else if (!m_stop) begin
            if (m_settled) begin
                if (tgt_i != m_cur) begin m_settled = 0; m_elapsed = 0; end
            end else if (tgt_i == m_cur) begin
                m_settled = 1; m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == DWELL) begin
                    m_cur = (tgt_i > m_cur) ? m_cur + 1 : m_cur - 1;
                    m_elapsed = 0;
                end
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == DWELL) begin
                m_elapsed = 0;
                if (m_cur > 0) m_cur = m_cur - 1;
                else m_en = 0;
            end
        end
    endfunction

    // ---------------- checking helpers ---------------------------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(string tag, int en, int spd, int bsy, int at);
        chk({tag, ".pwm_en"}, int'(pwm_en), en);
        chk({tag, ".pwm_speed"}, int'(pwm_speed), spd);
        chk({tag, ".busy"}, int'(busy), bsy);
        chk({tag, ".at_target"}, int'(at_target), at);
    endtask

    // One clock; outputs sampled 1 ns after the edge. Every cycle also
    // confirms the level never moves by more than one step.
    task automatic step_clk();
        int d;
        @(posedge clk);
        #1;
        d = int'(pwm_speed) - prev_speed;
        if (d < 0) d = -d;
        if (!jump_ok) begin
            checks++;
            if (d > 1) begin
                failures++;
                $display("FAIL speed_step actual_jump=%0d required<=1 (t=%0t)", d, $time);
            end
        end
        prev_speed = int'(pwm_speed);
    endtask

    task automatic do_reset();
        jump_ok = 1'b1;
        rst_n = 1'b0; run = 1'b0; target = '0;
`ifdef PWM_RAMP_ESTOP_EN
        estop = 1'b0;
`endif
        step_clk();
        step_clk();
        rst_n = 1'b1;
        jump_ok = 1'b0;
        model_reset();
    endtask

    initial begin
        // ---------------- reset values ----------------------------------
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
`ifdef PWM_RAMP_ESTOP_EN
        chk("reset.fault", int'(fault), 0);
`endif
        rst_n = 1'b1;
        step_clk();
        step_clk();
        chk_out("idle", 0, 0, 0, 0);

        // ---------------- table-driven ramp / stop ----------------------
        tbl.push_back(vec_t'{1, 5, 1, 1, 0, 1, 0});
        tbl.push_back(vec_t'{1, 5, 3, 1, 0, 1, 0});
        tbl.push_back(vec_t'{1, 5, 1, 1, 1, 1, 0});
        tbl.push_back(vec_t'{1, 5, 4, 1, 2, 1, 0});
        tbl.push_back(vec_t'{1, 5, 4, 1, 3, 1, 0});
        tbl.push_back(vec_t'{1, 5, 4, 1, 4, 1, 0});
        tbl.push_back(vec_t'{1, 5, 3, 1, 4, 1, 0});
        tbl.push_back(vec_t'{1, 5, 1, 1, 5, 1, 0});
        tbl.push_back(vec_t'{1, 5, 1, 1, 5, 0, 1});
        tbl.push_back(vec_t'{1, 5, 5, 1, 5, 0, 1});
        tbl.push_back(vec_t'{0, 5, 1, 1, 5, 1, 0});
        tbl.push_back(vec_t'{0, 5, 3, 1, 5, 1, 0});
        tbl.push_back(vec_t'{0, 5, 1, 1, 4, 1, 0});
        tbl.push_back(vec_t'{0, 5, 4, 1, 3, 1, 0});
        tbl.push_back(vec_t'{0, 5, 8, 1, 1, 1, 0});
        tbl.push_back(vec_t'{0, 5, 4, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 5, 3, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 5, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 5, 3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 1, 1, 0, 1, 0});
        tbl.push_back(vec_t'{1, 0, 1, 1, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 1, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 3, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{1, 7, 1, 1, 0, 1, 0});
        tbl.push_back(vec_t'{1, 7, 28, 1, 7, 1, 0});
        tbl.push_back(vec_t'{1, 7, 1, 1, 7, 0, 1});
        tbl.push_back(vec_t'{1, 3, 1, 1, 7, 1, 0});
        tbl.push_back(vec_t'{1, 3, 4, 1, 6, 1, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            run    = tbl[i].run;
            target = SPEED_W'(tbl[i].tgt);
            repeat (tbl[i].n) step_clk();
            chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].spd, tbl[i].busy, tbl[i].at);
        end

        // ---------------- redirect mid-ramp at cur=3 --------------------
        do_reset();
        run = 1'b1; target = 3'd5;
        step_clk();
        repeat (12) step_clk();
        chk_out("redir.at3", 1, 3, 1, 0);
        target = 3'd1;
        repeat (4) step_clk();
        chk_out("redir.to2", 1, 2, 1, 0);
        repeat (4) step_clk();
        chk_out("redir.to1", 1, 1, 1, 0);
        step_clk();
        chk_out("redir.hold", 1, 1, 0, 1);

        // ---------------- resume from STOP at cur=2 ---------------------
        do_reset();
        run = 1'b1; target = 3'd5;
        repeat (22) step_clk();
        chk_out("resume.hold5", 1, 5, 0, 1);
        run = 1'b0;
        step_clk();
        repeat (12) step_clk();
        chk_out("resume.stop2", 1, 2, 1, 0);
        run = 1'b1; target = 3'd6;
        step_clk();
        chk_out("resume.ramp", 1, 2, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step_clk();
            chk("resume.en_held", int'(pwm_en), 1);
        end
        chk("resume.speed6", int'(pwm_speed), 6);
        step_clk();
        chk_out("resume.hold6", 1, 6, 0, 1);

        // ---------------- asynchronous reset mid-ramp -------------------
        do_reset();
        run = 1'b1; target = 3'd7;
        repeat (6) step_clk();
        chk_out("arst.pre", 1, 1, 1, 0);
        #2;
        jump_ok = 1'b1;
        rst_n = 1'b0; run = 1'b0;
        #1;
        chk_out("arst.async", 0, 0, 0, 0);
        step_clk();
        chk_out("arst.held", 0, 0, 0, 0);
        rst_n = 1'b1;
        jump_ok = 1'b0;
        step_clk();
        chk_out("arst.idle", 0, 0, 0, 0);
        run = 1'b1; target = 3'd2;
        step_clk();
        chk_out("arst.restart", 1, 0, 1, 0);

`ifdef PWM_RAMP_ESTOP_EN
        // ---------------- emergency stop in HOLD at 6 -------------------
        do_reset();
        run = 1'b1; target = 3'd6;
        repeat (26) step_clk();
        chk_out("estop.hold6", 1, 6, 0, 1);
        estop = 1'b1; jump_ok = 1'b1;
        step_clk();
        estop = 1'b0; jump_ok = 1'b0;
        chk_out("estop.hit", 0, 0, 0, 0);
        chk("estop.fault_set", int'(fault), 1);
        for (int i = 0; i < 5; i++) begin
            step_clk();
            chk("estop.run_ignored", int'(pwm_en), 0);
            chk("estop.fault_sticky", int'(fault), 1);
        end
        run = 1'b0;
        step_clk();
        chk("estop.fault_clear", int'(fault), 0);
        chk("estop.still_idle", int'(pwm_en), 0);
        run = 1'b1;
        step_clk();
        chk_out("estop.restart", 1, 0, 1, 0);
`endif

        // ---------------- randomized stream vs model --------------------
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) target = SPEED_W'($urandom_range(0, 7));
`ifdef PWM_RAMP_ESTOP_EN
            estop = ($urandom_range(0, 299) == 0);
            cur_estop = estop;
`endif
            jump_ok = cur_estop;
            step_clk();
            model_edge(run, int'(target), cur_estop);
            chk_out("rand", int'(m_en), m_cur, int'(m_en && !m_settled), int'(m_settled));
`ifdef PWM_RAMP_ESTOP_EN
            chk("rand.fault", int'(fault), int'(m_fault));
`endif
        end
        jump_ok = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
